// File: rtl/plot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : plot_scheduler
//  Purpose  : Shares the VGA adapter pixel-write port between three 4x4
//             block-draw requesters (tail erase, head, food) using a
//             round-robin arbiter, and provides a full-screen clear sequence.
//  Revision : 1.0  initial release
// ============================================================================
module plot_scheduler #(
   parameter int         BLOCK_BITS   = 2,
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [23:0] req_x,
   input  logic [20:0] req_y,
   input  logic [8:0]  req_colour,
   input  logic        clear,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic        clear_done,
   output logic        busy,
   output logic [7:0]  x_out,
   output logic [6:0]  y_out,
   output logic [2:0]  colour_out,
   output logic        plot
);

   localparam int                 c_PIX_W    = 2 * BLOCK_BITS;
   localparam logic [c_PIX_W-1:0] c_PIX_LAST = {c_PIX_W{1'b1}};
   localparam logic [c_PIX_W-1:0] c_PIX_ONE  = c_PIX_W'(1);
   localparam logic [7:0]         c_CX_LAST  = 8'(SCREEN_W - 1);
   localparam logic [6:0]         c_CY_LAST  = 7'(SCREEN_H - 1);
   localparam logic [8:0]         c_W9       = 9'(SCREEN_W);
   localparam logic [7:0]         c_H8       = 8'(SCREEN_H);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_DRAW       = 3'd1,
      S_DONE       = 3'd2,
      S_CLEAR      = 3'd3,
      S_CLEAR_DONE = 3'd4
   } state_t;

   state_t               state_q;
   logic [2:0]           grant_q;
   logic [2:0]           done_q;
   logic                 clr_done_q;
   logic [1:0]           last_q;
   logic [c_PIX_W-1:0]   pix_q;
   logic [7:0]           bx_q;
   logic [6:0]           by_q;
   logic [2:0]           bc_q;
   logic [7:0]           cx_q;
   logic [6:0]           cy_q;

   // Round-robin selection results and the selected requester's block fields
   logic [1:0]           ord0, ord1, ord2;
   logic [1:0]           pick_d;
   logic [7:0]           sel_x_d;
   logic [6:0]           sel_y_d;
   logic [2:0]           sel_c_d;

   // Untruncated pixel coordinates inside the current block
   logic [8:0]           x_sum;
   logic [7:0]           y_sum;

   assign x_sum = {1'b0, bx_q} + 9'(pix_q[BLOCK_BITS-1:0]);
   assign y_sum = {1'b0, by_q} + 8'(pix_q[c_PIX_W-1:BLOCK_BITS]);

   // Search order starts one past the last served requester
   always_comb begin
      ord0 = 2'd0;
      ord1 = 2'd1;
      ord2 = 2'd2;
      case (last_q)
         2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
         2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
         default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
      endcase
      if (req[ord0])      pick_d = ord0;
      else if (req[ord1]) pick_d = ord1;
      else                pick_d = ord2;
   end

   // Route the chosen requester's corner and colour to the latch inputs
   always_comb begin
      sel_x_d = req_x[7:0];
      sel_y_d = req_y[6:0];
      sel_c_d = req_colour[2:0];
      case (pick_d)
         2'd1: begin
            sel_x_d = req_x[15:8];
            sel_y_d = req_y[13:7];
            sel_c_d = req_colour[5:3];
         end
         2'd2: begin
            sel_x_d = req_x[23:16];
            sel_y_d = req_y[20:14];
            sel_c_d = req_colour[8:6];
         end
         default: begin
            sel_x_d = req_x[7:0];
            sel_y_d = req_y[6:0];
            sel_c_d = req_colour[2:0];
         end
      endcase
   end

   // Control FSM: arbitration, block walk, clear raster and handshake pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         grant_q    <= 3'b000;
         done_q     <= 3'b000;
         clr_done_q <= 1'b0;
         last_q     <= 2'd2;
         pix_q      <= '0;
         bx_q       <= 8'd0;
         by_q       <= 7'd0;
         bc_q       <= 3'd0;
         cx_q       <= 8'd0;
         cy_q       <= 7'd0;
      end else begin
         done_q     <= 3'b000;
         clr_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Clear outranks every block request; pointer is left alone
               if (clear) begin
                  cx_q    <= 8'd0;
                  cy_q    <= 7'd0;
                  state_q <= S_CLEAR;
               end else if (|req) begin
                  bx_q    <= sel_x_d;
                  by_q    <= sel_y_d;
                  bc_q    <= sel_c_d;
                  grant_q <= 3'b001 << pick_d;
                  last_q  <= pick_d;
                  pix_q   <= '0;
                  state_q <= S_DRAW;
               end
            end
            S_DRAW: begin
               pix_q <= pix_q + c_PIX_ONE;
               if (pix_q == c_PIX_LAST) begin
                  done_q  <= grant_q;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               grant_q <= 3'b000;
               state_q <= S_IDLE;
            end
            S_CLEAR: begin
               if (cx_q == c_CX_LAST) begin
                  cx_q <= 8'd0;
                  if (cy_q == c_CY_LAST) begin
                     clr_done_q <= 1'b1;
                     state_q    <= S_CLEAR_DONE;
                  end else begin
                     cy_q <= cy_q + 7'd1;
                  end
               end else begin
                  cx_q <= cx_q + 8'd1;
               end
            end
            S_CLEAR_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Pixel port driven straight from state so the first pixel lands in the first DRAW cycle
   always_comb begin
      x_out      = 8'd0;
      y_out      = 7'd0;
      colour_out = 3'd0;
      plot       = 1'b0;
      case (state_q)
         S_DRAW: begin
            x_out      = x_sum[7:0];
            y_out      = y_sum[6:0];
            colour_out = bc_q;
            plot       = (x_sum < c_W9) && (y_sum < c_H8);
         end
         S_CLEAR: begin
            x_out      = cx_q;
            y_out      = cy_q;
            colour_out = CLEAR_COLOUR;
            plot       = 1'b1;
         end
         default: begin
            plot = 1'b0;
         end
      endcase
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign clear_done = clr_done_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
